// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath blocks.
// Holds the feeder FSM state type and the default element width.
package tpu_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int TILE_DIM       = 2;

  typedef enum logic [1:0] {
    IDLE,
    FEED0,
    FEED1,
    FEED2
  } feeder_state_e;

endpackage

// File: rtl/ub_tile_feeder.sv
// Captures a 2x2 tile from the unified buffer and feeds it into the array's
// left edge with a one-cycle diagonal skew between row 0 and row 1.
module ub_tile_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_00,
  input  logic [DATA_W-1:0] in_01,
  input  logic [DATA_W-1:0] in_10,
  input  logic [DATA_W-1:0] in_11,
  output logic              in_ready,
  output logic [DATA_W-1:0] row0_data,
  output logic [DATA_W-1:0] row1_data,
  output logic              row0_valid,
  output logic              row1_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        tile_count
);

  feeder_state_e     state;
  logic [DATA_W-1:0] tile_01;
  logic [DATA_W-1:0] tile_10;
  logic [DATA_W-1:0] tile_11;
  logic              accept;

  assign in_ready = (state == IDLE) || (state == FEED2);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // a00 goes straight into the row 0 output register on the accept edge,
  // so only the three later elements need to be held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tile_01    <= '0;
      tile_10    <= '0;
      tile_11    <= '0;
      row0_data  <= '0;
      row1_data  <= '0;
      row0_valid <= 1'b0;
      row1_valid <= 1'b0;
      done       <= 1'b0;
      tile_count <= 8'd0;
    end else begin
      row0_data  <= '0;
      row1_data  <= '0;
      row0_valid <= 1'b0;
      row1_valid <= 1'b0;
      done       <= 1'b0;

      case (state)
        IDLE: begin
          state <= IDLE;
        end
        FEED0: begin
          state      <= FEED1;
          row0_data  <= tile_01;
          row0_valid <= 1'b1;
          row1_data  <= tile_10;
          row1_valid <= 1'b1;
        end
        FEED1: begin
          state      <= FEED2;
          row1_data  <= tile_11;
          row1_valid <= 1'b1;
          done       <= 1'b1;
        end
        FEED2: begin
          state      <= IDLE;
          tile_count <= tile_count + 8'd1;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Accept is only possible in IDLE or FEED2; it overrides the exit above
      // so back-to-back tiles stream without a bubble.
      if (accept) begin
        state      <= FEED0;
        tile_01    <= in_01;
        tile_10    <= in_10;
        tile_11    <= in_11;
        row0_data  <= in_00;
        row0_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ub_tile_feeder.sv
// Randomized scoreboard bench for ub_tile_feeder with a 16-bit element width.
module tb_ub_tile_feeder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_00, in_01, in_10, in_11;
  logic        in_ready;
  logic [15:0] row0_data, row1_data;
  logic        row0_valid, row1_valid;
  logic        busy, done;
  logic [7:0]  tile_count;

  int          checks_total  = 0;
  int          checks_passed = 0;
  int          model_wait    = 0;
  int          tile_idx      = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_act;

  ub_tile_feeder #(.DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_00      (in_00),
    .in_01      (in_01),
    .in_10      (in_10),
    .in_11      (in_11),
    .in_ready   (in_ready),
    .row0_data  (row0_data),
    .row1_data  (row1_data),
    .row0_valid (row0_valid),
    .row1_valid (row1_valid),
    .busy       (busy),
    .done       (done),
    .tile_count (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] packBeat(input logic [15:0] r0, input logic v0,
                                           input logic [15:0] r1, input logic v1,
                                           input logic d, input logic [7:0] cnt,
                                           input logic b);
    return {20'd0, r0, v0, r1, v1, d, cnt, b};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // A tile accepted as the k-th since reset shows three beats, all carrying k mod 256.
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d,
                               output logic accepted);
    logic       ready_exp;
    logic [7:0] cnt;
    in_valid = v;
    in_00 = a; in_01 = b; in_10 = c; in_11 = d;
    #1;
    ready_exp = (model_wait == 0);
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, ready_exp});
    @(posedge clk);
    accepted = v && ready_exp;
    if (accepted) begin
      cnt = 8'(tile_idx);
      exp_q.push_back(packBeat(a, 1'b1, 16'd0, 1'b0, 1'b0, cnt, 1'b1));
      exp_q.push_back(packBeat(b, 1'b1, c, 1'b1, 1'b0, cnt, 1'b1));
      exp_q.push_back(packBeat(16'd0, 1'b0, d, 1'b1, 1'b1, cnt, 1'b1));
      tile_idx++;
      model_wait = 2;
    end else if (model_wait > 0) begin
      model_wait--;
    end
    #1;
  endtask

  task automatic sendTile(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 4) begin
      applyStimulus(1'b1, a, b, c, d, acc);
      tries++;
    end
    if (!acc) checkOutput("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, acc);
  endtask

  // Every FEED cycle drives at least one valid or done, so a quiet output
  // means the feeder is idle and nothing should still be expected.
  always @(negedge clk) begin
    if (!reset) begin
      mon_act = packBeat(row0_data, row0_valid, row1_data, row1_valid, done, tile_count, busy);
      if (row0_valid || row1_valid || done) begin
        if (exp_q.size() == 0) checkOutput("unexpected_beat", mon_act, 64'd0);
        else checkOutput("beat", mon_act, exp_q.pop_front());
      end else begin
        checkOutput("idle_outputs", {30'd0, row0_data, row1_data, busy, done}, 64'd0);
        checkOutput("missing_beat", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  initial begin
    logic acc;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_00 = 16'h1111; in_01 = 16'h2222; in_10 = 16'h3333; in_11 = 16'h4444;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {28'd0, row0_data, row1_data, row0_valid, row1_valid, busy, done},
                64'd0);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("ready_after_reset", {63'd0, in_ready}, 64'd1);
    checkOutput("count_after_reset", {56'd0, tile_count}, 64'd0);

    // Single tile from idle
    applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'd4, acc);
    idleCycles(5);
    checkOutput("count_single", {56'd0, tile_count}, 64'd1);

    // Back-to-back with in_valid held, second tile presented early
    sendTile(16'd1, 16'd2, 16'd3, 16'd4);
    sendTile(16'd5, 16'd6, 16'd7, 16'd8);
    idleCycles(4);

    // Stall: in_valid only during FEED0/FEED1 must be ignored
    applyStimulus(1'b1, 16'd1, 16'd2, 16'd3, 16'd4, acc);
    applyStimulus(1'b1, 16'd9, 16'd9, 16'd9, 16'd9, acc);
    applyStimulus(1'b1, 16'd9, 16'd9, 16'd9, 16'd9, acc);
    idleCycles(3);

    // Full-width element values
    sendTile(16'hFFFF, 16'h0000, 16'hFFFF, 16'h8001);
    sendTile(16'h0000, 16'hFFFF, 16'h7FFE, 16'hFFFF);
    idleCycles(4);
    checkOutput("count_directed", {56'd0, tile_count}, 64'(tile_idx % 256));

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), acc);
    end
    idleCycles(4);
    checkOutput("count_random", {56'd0, tile_count}, 64'(tile_idx % 256));

    // Reset asserted in the middle of a tile (FEED1)
    applyStimulus(1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, acc);
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, acc);
    reset = 1'b1;
    exp_q.delete();
    model_wait = 0;
    tile_idx   = 0;
    #1;
    checkOutput("midtile_reset",
                {28'd0, row0_data, row1_data, row0_valid, row1_valid, busy, done},
                64'd0);
    checkOutput("midtile_reset_count", {56'd0, tile_count}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ready_after_midtile", {63'd0, in_ready}, 64'd1);
    checkOutput("count_after_midtile", {56'd0, tile_count}, 64'd0);

    // 256 streamed tiles: count reads 255 in the last FEED2, then wraps to 0
    for (int k = 0; k < 256; k++) begin
      sendTile(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    idleCycles(4);
    checkOutput("count_wrap", {56'd0, tile_count}, 64'd0);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
